// File: rtl/lfsr_cap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_cap_pkg
//  Description : Shared constants and types for the LFSR output capture stage.
//                Sample width, MISR feedback taps and the sample type.
//  Revision    : 1.0  initial release
// ============================================================================
package lfsr_cap_pkg;

    // Sample width, equal to the width of the upstream generator output.
    localparam int DATA_W = 11;

    // MISR feedback taps for x^11 + x^9 + 1. These are bit indices into the
    // signature register: the bit shifted out and the bit two below it.
    localparam int MISR_TAP_HI = 10;
    localparam int MISR_TAP_LO = 8;

    // One captured sample.
    typedef logic [DATA_W-1:0] sample_t;

endpackage : lfsr_cap_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with first-word fall-through head.
//                Accepts a push while full when a pop happens in the same
//                cycle. Holds the last popped head on o_data while empty.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo
    import lfsr_cap_pkg::*;
#(
    parameter  int DATA_W = lfsr_cap_pkg::DATA_W,
    parameter  int DEPTH  = 8,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_last_head;

    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);

    // A pop on an empty FIFO is ignored; a push on a full FIFO only lands
    // when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage array: written at the tail, no reset needed since the empty
    // mux below hides any unwritten entry.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Remember the head as it leaves so o_data stays stable once empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_head <= '0;
        end else if (w_do_pop) begin
            r_last_head <= r_mem[r_rd_ptr];
        end
    end

    assign o_data  = o_empty ? r_last_head : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/lfsr_out_capture.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_out_capture
//  Description : Capture stage for the LFSR generator output. Buffers
//                samples in a small FIFO drained over valid/ready, folds
//                every accepted sample into an MISR signature, flags a
//                stuck generator and records dropped samples.
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr_out_capture
    import lfsr_cap_pkg::*;
#(
    parameter int DATA_W    = lfsr_cap_pkg::DATA_W,
    parameter int DEPTH     = 8,
    parameter int STUCK_LIM = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DATA_W-1:0]        signature,
    output logic                     stuck,
    input  logic                     sig_clear
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int RUN_W = $clog2(STUCK_LIM);

    // Feedback taps: the package values describe the default 11-bit
    // polynomial; other widths fall back to the same x^N + x^(N-2) + 1 form.
    localparam int c_TAP_HI = (DATA_W == lfsr_cap_pkg::DATA_W) ? MISR_TAP_HI : DATA_W - 1;
    localparam int c_TAP_LO = (DATA_W == lfsr_cap_pkg::DATA_W) ? MISR_TAP_LO : DATA_W - 3;

    localparam logic [RUN_W-1:0] c_RUN_MAX = RUN_W'(STUCK_LIM - 1);

    // ------------------------------------------------------------------
    // Handshake glue
    // ------------------------------------------------------------------
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic [CNT_W-1:0]  w_count;
    logic [DATA_W-1:0] w_head;

    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    // Ready while there is room, or when the head is leaving this cycle.
    assign in_ready  = !w_full || w_pop;
    assign w_push    = in_valid && in_ready;
    assign w_drop    = in_valid && !in_ready;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign out_data = w_head;
    assign count    = w_count;

    // ------------------------------------------------------------------
    // MISR signature
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_sig;
    logic [DATA_W-1:0] w_sig_next;

    assign w_sig_next = {r_sig[DATA_W-2:0], r_sig[c_TAP_HI] ^ r_sig[c_TAP_LO]} ^ in_data;

    // Fold each accepted sample into the signature; clear wins over a push.
    always_ff @(posedge clk) begin
        if (rst || sig_clear) begin
            r_sig <= '0;
        end else if (w_push) begin
            r_sig <= w_sig_next;
        end
    end

    assign signature = r_sig;

    // ------------------------------------------------------------------
    // Stuck-generator detector
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_prev;
    logic [RUN_W-1:0]  r_run;
    logic              r_stuck;
    logic [RUN_W-1:0]  w_run_next;

    // Run length of repeats for the current sample, saturating at the limit.
    always_comb begin
        w_run_next = '0;
        if (in_data == r_prev) begin
            w_run_next = (r_run == c_RUN_MAX) ? r_run : r_run + 1'b1;
        end
    end

    // Track previous accepted sample and raise the sticky flag on a full run.
    always_ff @(posedge clk) begin
        if (rst || sig_clear) begin
            r_prev  <= '0;
            r_run   <= '0;
            r_stuck <= 1'b0;
        end else if (w_push) begin
            r_prev <= in_data;
            r_run  <= w_run_next;
            if (w_run_next == c_RUN_MAX) begin
                r_stuck <= 1'b1;
            end
        end
    end

    assign stuck = r_stuck;

    // ------------------------------------------------------------------
    // Overflow flag
    // ------------------------------------------------------------------
    logic r_overflow;

    // Sticky record of a sample offered while the FIFO could not take it.
    always_ff @(posedge clk) begin
        if (rst || sig_clear) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;

endmodule : lfsr_out_capture
`default_nettype wire

// File: tb/tb_lfsr_out_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_out_capture
//  Description : Self-checking bench for lfsr_out_capture: a directed vector
//                table plus hand-written drain, clear and streaming sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lfsr_out_capture;

    localparam int DW    = lfsr_cap_pkg::DATA_W;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          overflow;
    logic [DW-1:0] signature;
    logic          stuck;
    logic          sig_clear;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lfsr_out_capture #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .STUCK_LIM (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .signature (signature),
        .stuck     (stuck),
        .sig_clear (sig_clear)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          rst;
        logic          iv;
        logic [DW-1:0] din;
        logic          ordy;
        logic          clr;
        logic          chk_rdy;
        logic          rdy;
        logic [CW-1:0] cnt;
        logic          oval;
        logic [DW-1:0] odata;
        logic          ovf;
        logic [DW-1:0] sig;
        logic          stk;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic iv, input logic [DW-1:0] d,
                                input logic ordy, input logic clr, input logic chk,
                                input logic rdy, input logic [CW-1:0] cnt, input logic ov,
                                input logic [DW-1:0] od, input logic ovf,
                                input logic [DW-1:0] sg, input logic stk);
        vec_t v;
        v.rst = r; v.iv = iv; v.din = d; v.ordy = ordy; v.clr = clr;
        v.chk_rdy = chk; v.rdy = rdy; v.cnt = cnt; v.oval = ov; v.odata = od;
        v.ovf = ovf; v.sig = sg; v.stk = stk;
        return v;
    endfunction

    // Independent reference for the signature update (x^11 + x^9 + 1).
    function automatic logic [DW-1:0] ref_misr(input logic [DW-1:0] s, input logic [DW-1:0] d);
        logic [DW-1:0] sh;
        sh = {s[DW-2:0], s[10] ^ s[8]};
        return sh ^ d;
    endfunction

    vec_t vt[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] q[$];
        logic [DW-1:0] gen;
        logic [DW-1:0] msig;
        logic [DW-1:0] mprev;
        int            mrun;
        logic          mstuck;
        int            k;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sig_clear = 1'b0;

        //        rst iv  din    ordy clr chk rdy cnt oval odata  ovf sig    stk
        vt.push_back(mk(1, 0, 11'h000, 0, 0, 0, 0, 0, 0, 11'h000, 0, 11'h000, 0));
        vt.push_back(mk(1, 0, 11'h000, 0, 0, 0, 0, 0, 0, 11'h000, 0, 11'h000, 0));
        vt.push_back(mk(0, 1, 11'h001, 0, 0, 1, 1, 1, 1, 11'h001, 0, 11'h001, 0));
        vt.push_back(mk(0, 1, 11'h001, 0, 0, 1, 1, 2, 1, 11'h001, 0, 11'h003, 0));
        vt.push_back(mk(0, 1, 11'h002, 0, 0, 1, 1, 3, 1, 11'h001, 0, 11'h004, 0));
        vt.push_back(mk(0, 1, 11'h004, 0, 0, 1, 1, 4, 1, 11'h001, 0, 11'h00C, 0));
        vt.push_back(mk(0, 1, 11'h008, 0, 0, 1, 1, 5, 1, 11'h001, 0, 11'h010, 0));
        vt.push_back(mk(0, 1, 11'h010, 0, 0, 1, 1, 6, 1, 11'h001, 0, 11'h030, 0));
        vt.push_back(mk(0, 1, 11'h020, 0, 0, 1, 1, 7, 1, 11'h001, 0, 11'h040, 0));
        vt.push_back(mk(0, 1, 11'h040, 0, 0, 1, 1, 8, 1, 11'h001, 0, 11'h0C0, 0));
        // full, no pop: sample dropped
        vt.push_back(mk(0, 1, 11'h7FF, 0, 0, 1, 0, 8, 1, 11'h001, 1, 11'h0C0, 0));
        // full with pop: push and pop together
        vt.push_back(mk(0, 1, 11'h7FF, 1, 0, 1, 1, 8, 1, 11'h001, 1, 11'h67F, 0));
        vt.push_back(mk(0, 0, 11'h000, 1, 0, 1, 1, 7, 1, 11'h002, 1, 11'h67F, 0));
        vt.push_back(mk(0, 0, 11'h000, 0, 1, 1, 1, 7, 1, 11'h002, 0, 11'h000, 0));
        // reset mid-traffic, two cycles
        vt.push_back(mk(1, 1, 11'h3FF, 1, 0, 1, 1, 0, 0, 11'h000, 0, 11'h000, 0));
        vt.push_back(mk(1, 1, 11'h3FF, 1, 0, 1, 1, 0, 0, 11'h000, 0, 11'h000, 0));
        // repeated sample: stuck after fourth push only
        vt.push_back(mk(0, 1, 11'h2A5, 0, 0, 1, 1, 1, 1, 11'h2A5, 0, 11'h2A5, 0));
        vt.push_back(mk(0, 1, 11'h2A5, 0, 0, 1, 1, 2, 1, 11'h2A5, 0, 11'h7EF, 0));
        vt.push_back(mk(0, 1, 11'h2A5, 0, 0, 1, 1, 3, 1, 11'h2A5, 0, 11'h57B, 0));
        vt.push_back(mk(0, 1, 11'h2A5, 0, 0, 1, 1, 4, 1, 11'h2A5, 0, 11'h053, 1));
        vt.push_back(mk(0, 0, 11'h000, 0, 1, 1, 1, 4, 1, 11'h2A5, 0, 11'h000, 0));

        foreach (vt[i]) begin
            @(negedge clk);
            rst = vt[i].rst; in_valid = vt[i].iv; in_data = vt[i].din;
            out_ready = vt[i].ordy; sig_clear = vt[i].clr;
            #1;
            if (vt[i].chk_rdy) check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vt[i].rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d count", i),     32'(count),     32'(vt[i].cnt));
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vt[i].oval));
            check($sformatf("v%0d out_data", i),  32'(out_data),  32'(vt[i].odata));
            check($sformatf("v%0d overflow", i),  32'(overflow),  32'(vt[i].ovf));
            check($sformatf("v%0d signature", i), 32'(signature), 32'(vt[i].sig));
            check($sformatf("v%0d stuck", i),     32'(stuck),     32'(vt[i].stk));
        end

        // Drain to empty; the last head value must stay on out_data.
        k = 0;
        while (out_valid && k < 16) begin
            @(negedge clk);
            rst = 1'b0; in_valid = 1'b0; sig_clear = 1'b0; out_ready = 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        check("drain out_valid", 32'(out_valid), 32'(0));
        check("drain count", 32'(count), 32'(0));
        check("drain hold data", 32'(out_data), 32'(11'h2A5));

        // Push into empty together with sig_clear.
        @(negedge clk);
        in_valid = 1'b1; in_data = 11'h123; out_ready = 1'b0; sig_clear = 1'b1;
        #1;
        check("clr push in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        check("clr push out_valid", 32'(out_valid), 32'(1));
        check("clr push out_data", 32'(out_data), 32'(11'h123));
        check("clr push signature", 32'(signature), 32'(0));
        check("clr push count", 32'(count), 32'(1));
        @(negedge clk);
        in_valid = 1'b0; sig_clear = 1'b0;
        @(posedge clk);
        #1;
        check("idle signature", 32'(signature), 32'(0));

        // Streaming: push and pop each cycle against a scoreboard and model.
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        gen = 11'd150; msig = '0; mprev = '0; mrun = 0; mstuck = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = gen; out_ready = 1'b1;
            #1;
            if (out_valid) begin
                if (q.size() == 0) check("stream unexpected valid", 32'(out_valid), 32'(0));
                else check($sformatf("stream order %0d", c), 32'(out_data), 32'(q.pop_front()));
            end
            check($sformatf("stream in_ready %0d", c), 32'(in_ready), 32'(1));
            q.push_back(gen);
            msig = ref_misr(msig, gen);
            if (gen == mprev) mrun = (mrun < 3) ? mrun + 1 : 3;
            else mrun = 0;
            if (mrun == 3) mstuck = 1'b1;
            mprev = gen;
            gen = {gen[DW-2:0], gen[10] ^ gen[8]};
            @(posedge clk);
            #1;
            check($sformatf("stream count<=1 %0d", c), 32'(count <= 1), 32'(1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (q.size() > 0 && k < 10) begin
            #1;
            if (out_valid) check("stream drain order", 32'(out_data), 32'(q.pop_front()));
            else check("stream drain valid", 32'(out_valid), 32'(1));
            @(posedge clk);
            #1;
            @(negedge clk);
            k++;
        end
        check("stream queue empty", 32'(q.size()), 32'(0));
        check("stream signature", 32'(signature), 32'(msig));
        check("stream stuck", 32'(stuck), 32'(mstuck));
        check("stream out_valid end", 32'(out_valid), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_lfsr_out_capture
`default_nettype wire
